// File: rtl/hynoc_packet_tx.sv
// -----------------------------------------------------------------------------
// hynoc_packet_tx
//   Turns a packet command (header word + payload length) plus a stream of
//   payload words into flits for a router ingress FIFO. Each packet is one
//   header flit followed by cmd_length payload flits; the last flit of the
//   packet carries tail=1 in bit FLIT_WIDTH-1.
//
// Ports
//   router_clk    in   sole clock, rising edge
//   router_srst   in   synchronous active-high reset
//   cmd_valid     in   packet command present
//   cmd_ready     out  command accepted on cmd_valid && cmd_ready (IDLE only)
//   cmd_header    in   routing header word
//   cmd_length    in   payload flits following the header (0 legal)
//   pld_valid     in   payload word present
//   pld_ready     out  payload word consumed on pld_valid && pld_ready
//   pld_data      in   payload word
//   ingress_write out  flit write strobe toward the router ingress FIFO
//   ingress_data  out  flit {tail, payload}
//   ingress_full  in   router ingress FIFO full
//   busy          out  packet in progress
//   pkt_count     out  completed packets, wraps at 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module hynoc_packet_tx #(
  parameter int PAYLOAD_WIDTH = 32,
  parameter int FLIT_WIDTH    = PAYLOAD_WIDTH + 1,
  parameter int LEN_WIDTH     = 8,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     router_clk,
  input  logic                     router_srst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [PAYLOAD_WIDTH-1:0] cmd_header,
  input  logic [LEN_WIDTH-1:0]     cmd_length,
  input  logic                     pld_valid,
  output logic                     pld_ready,
  input  logic [PAYLOAD_WIDTH-1:0] pld_data,
  output logic                     ingress_write,
  output logic [FLIT_WIDTH-1:0]    ingress_data,
  input  logic                     ingress_full,
  output logic                     busy,
  output logic [CNT_WIDTH-1:0]     pkt_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2
  } state_e;

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = LEN_WIDTH'(0);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_e                   state_q, state_d;
  logic [PAYLOAD_WIDTH-1:0] hdr_q, hdr_d;
  logic [LEN_WIDTH-1:0]     remain_q, remain_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;

  // State and datapath registers; reset wins over a same-cycle command.
  always_ff @(posedge router_clk) begin
    if (router_srst) begin
      state_q  <= S_IDLE;
      hdr_q    <= '0;
      remain_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      remain_q <= remain_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic and the combinational flit/handshake outputs.
  always_comb begin
    state_d       = state_q;
    hdr_d         = hdr_q;
    remain_d      = remain_q;
    cnt_d         = cnt_q;
    cmd_ready     = 1'b0;
    pld_ready     = 1'b0;
    ingress_write = 1'b0;
    ingress_data  = '0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          hdr_d    = cmd_header;
          remain_d = cmd_length;
          state_d  = S_HEADER;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_HEADER: begin
        // A zero-length packet is a single flit, so the header is its tail.
        ingress_write = !ingress_full;
        ingress_data  = FLIT_WIDTH'({(remain_q == LEN_ZERO), hdr_q});
        if (!ingress_full) begin
          if (remain_q != LEN_ZERO) begin
            state_d = S_PAYLOAD;
          end else begin
            state_d = S_IDLE;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = S_HEADER;
        end
      end

      S_PAYLOAD: begin
        // Consumption of a payload word and the flit write are the same event,
        // so a full FIFO holds the word at the source rather than dropping it.
        pld_ready     = !ingress_full;
        ingress_write = pld_valid && !ingress_full;
        ingress_data  = FLIT_WIDTH'({(remain_q == LEN_ONE), pld_data});
        if (pld_valid && !ingress_full) begin
          remain_d = remain_q - LEN_ONE;
          if (remain_q == LEN_ONE) begin
            state_d = S_IDLE;
            cnt_d   = cnt_q + CNT_ONE;
          end else begin
            state_d = S_PAYLOAD;
          end
        end else begin
          state_d = S_PAYLOAD;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign pkt_count = cnt_q;

endmodule

// File: tb/tb_hynoc_packet_tx.sv
module tb_hynoc_packet_tx;

  localparam int PW = 32;
  localparam int FW = PW + 1;
  localparam int LW = 8;
  // Narrow counter so the wrap case fits in a short run.
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          router_srst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [PW-1:0] cmd_header;
  logic [LW-1:0] cmd_length;
  logic          pld_valid;
  logic          pld_ready;
  logic [PW-1:0] pld_data;
  logic          ingress_write;
  logic [FW-1:0] ingress_data;
  logic          ingress_full;
  logic          busy;
  logic [CW-1:0] pkt_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hynoc_packet_tx #(
    .PAYLOAD_WIDTH(PW),
    .FLIT_WIDTH   (FW),
    .LEN_WIDTH    (LW),
    .CNT_WIDTH    (CW)
  ) dut (
    .router_clk   (clk),
    .router_srst  (router_srst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_header   (cmd_header),
    .cmd_length   (cmd_length),
    .pld_valid    (pld_valid),
    .pld_ready    (pld_ready),
    .pld_data     (pld_data),
    .ingress_write(ingress_write),
    .ingress_data (ingress_data),
    .ingress_full (ingress_full),
    .busy         (busy),
    .pkt_count    (pkt_count)
  );

  typedef struct {
    string         name;
    logic          srst;
    logic          cv;
    logic [PW-1:0] hdr;
    logic [LW-1:0] len;
    logic          pv;
    logic [PW-1:0] pd;
    logic          full;
    logic          e_cr;
    logic          e_pr;
    logic          e_wr;
    logic [FW-1:0] e_d;
    logic          e_busy;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [FW-1:0] flit(input logic tail, input logic [PW-1:0] w);
    return {tail, w};
  endfunction

  task automatic add(input string nm, input logic srst, input logic cv,
                     input logic [PW-1:0] hdr, input logic [LW-1:0] len,
                     input logic pv, input logic [PW-1:0] pd, input logic full,
                     input logic e_cr, input logic e_pr, input logic e_wr,
                     input logic [FW-1:0] e_d, input logic e_busy,
                     input logic [CW-1:0] e_cnt);
    vec_t v;
    v.name = nm; v.srst = srst; v.cv = cv; v.hdr = hdr; v.len = len;
    v.pv = pv; v.pd = pd; v.full = full;
    v.e_cr = e_cr; v.e_pr = e_pr; v.e_wr = e_wr; v.e_d = e_d;
    v.e_busy = e_busy; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic srst, input logic cv, input logic [PW-1:0] hdr,
                       input logic [LW-1:0] len, input logic pv,
                       input logic [PW-1:0] pd, input logic full);
    router_srst  = srst;
    cmd_valid    = cv;
    cmd_header   = hdr;
    cmd_length   = len;
    pld_valid    = pv;
    pld_data     = pd;
    ingress_full = full;
  endtask

  // Compares the outputs of the current cycle at the falling edge, then
  // advances to just after the next rising edge.
  task automatic check(input string nm, input logic e_cr, input logic e_pr,
                       input logic e_wr, input logic [FW-1:0] e_d,
                       input logic e_busy, input logic [CW-1:0] e_cnt);
    logic [FW+CW+3:0] got;
    logic [FW+CW+3:0] exp;
    @(negedge clk);
    got = {cmd_ready, pld_ready, ingress_write, ingress_data, busy, pkt_count};
    exp = {e_cr, e_pr, e_wr, e_d, e_busy, e_cnt};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got cr=%b pr=%b wr=%b data=%h busy=%b cnt=%0d, expected cr=%b pr=%b wr=%b data=%h busy=%b cnt=%0d",
               nm, cmd_ready, pld_ready, ingress_write, ingress_data, busy, pkt_count,
               e_cr, e_pr, e_wr, e_d, e_busy, e_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad_tails;
    //   name           srst cv hdr          len   pv pd         full  cr pr wr data                    busy cnt
    add("rst_cmd",      1'b1,1'b1,32'h99,    8'd1, 1'b0,32'h0,   1'b0, 1'b1,1'b0,1'b0,flit(1'b0,32'h0), 1'b0,8'd0);
    add("rst_idle",     1'b0,1'b0,32'h0,     8'd0, 1'b0,32'h0,   1'b0, 1'b1,1'b0,1'b0,flit(1'b0,32'h0), 1'b0,8'd0);
    // len=3 packet; payload offered in IDLE/HEADER must not be consumed
    add("039_accept",   1'b0,1'b1,32'h0A05,  8'd3, 1'b1,32'h55,  1'b0, 1'b1,1'b0,1'b0,flit(1'b0,32'h0), 1'b0,8'd0);
    add("039_hdr",      1'b0,1'b0,32'h0,     8'd0, 1'b1,32'h11,  1'b0, 1'b0,1'b0,1'b1,flit(1'b0,32'h0A05),1'b1,8'd0);
    add("039_p1",       1'b0,1'b0,32'h0,     8'd0, 1'b1,32'h11,  1'b0, 1'b0,1'b1,1'b1,flit(1'b0,32'h11),1'b1,8'd0);
    add("039_p2",       1'b0,1'b0,32'h0,     8'd0, 1'b1,32'h22,  1'b0, 1'b0,1'b1,1'b1,flit(1'b0,32'h22),1'b1,8'd0);
    add("039_p3_tail",  1'b0,1'b0,32'h0,     8'd0, 1'b1,32'h33,  1'b0, 1'b0,1'b1,1'b1,flit(1'b1,32'h33),1'b1,8'd0);
    // IDLE with count 1, accepting a zero-length packet
    add("040_accept",   1'b0,1'b1,32'hABCD,  8'd0, 1'b0,32'h0,   1'b0, 1'b1,1'b0,1'b0,flit(1'b0,32'h0), 1'b0,8'd1);
    add("040_hdr_tail", 1'b0,1'b0,32'h0,     8'd0, 1'b0,32'h0,   1'b0, 1'b0,1'b0,1'b1,flit(1'b1,32'hABCD),1'b1,8'd1);
    // back in IDLE, accepting len=2 whose header meets a full FIFO
    add("041_accept",   1'b0,1'b1,32'h41,    8'd2, 1'b0,32'h0,   1'b0, 1'b1,1'b0,1'b0,flit(1'b0,32'h0), 1'b0,8'd2);
    for (int i = 0; i < 5; i++)
      add("041_full",   1'b0,1'b0,32'h0,     8'd0, 1'b1,32'hA1,  1'b1, 1'b0,1'b0,1'b0,flit(1'b0,32'h41),1'b1,8'd2);
    add("041_hdr",      1'b0,1'b0,32'h0,     8'd0, 1'b1,32'hA1,  1'b0, 1'b0,1'b0,1'b1,flit(1'b0,32'h41),1'b1,8'd2);
    add("041_p1",       1'b0,1'b0,32'h0,     8'd0, 1'b1,32'hA1,  1'b0, 1'b0,1'b1,1'b1,flit(1'b0,32'hA1),1'b1,8'd2);
    add("041_p2_tail",  1'b0,1'b0,32'h0,     8'd0, 1'b1,32'hA2,  1'b0, 1'b0,1'b1,1'b1,flit(1'b1,32'hA2),1'b1,8'd2);
    // len=4 with pld_valid pattern 1,0,0,1,1,1
    add("042_accept",   1'b0,1'b1,32'h42,    8'd4, 1'b0,32'h0,   1'b0, 1'b1,1'b0,1'b0,flit(1'b0,32'h0), 1'b0,8'd3);
    add("042_hdr",      1'b0,1'b0,32'h0,     8'd0, 1'b1,32'hB1,  1'b0, 1'b0,1'b0,1'b1,flit(1'b0,32'h42),1'b1,8'd3);
    add("042_p1",       1'b0,1'b0,32'h0,     8'd0, 1'b1,32'hB1,  1'b0, 1'b0,1'b1,1'b1,flit(1'b0,32'hB1),1'b1,8'd3);
    add("042_stall_a",  1'b0,1'b0,32'h0,     8'd0, 1'b0,32'hB2,  1'b0, 1'b0,1'b1,1'b0,flit(1'b0,32'hB2),1'b1,8'd3);
    add("042_stall_b",  1'b0,1'b0,32'h0,     8'd0, 1'b0,32'hB2,  1'b0, 1'b0,1'b1,1'b0,flit(1'b0,32'hB2),1'b1,8'd3);
    add("042_p2",       1'b0,1'b0,32'h0,     8'd0, 1'b1,32'hB2,  1'b0, 1'b0,1'b1,1'b1,flit(1'b0,32'hB2),1'b1,8'd3);
    add("042_p3",       1'b0,1'b0,32'h0,     8'd0, 1'b1,32'hB3,  1'b0, 1'b0,1'b1,1'b1,flit(1'b0,32'hB3),1'b1,8'd3);
    add("042_p4_tail",  1'b0,1'b0,32'h0,     8'd0, 1'b1,32'hB4,  1'b0, 1'b0,1'b1,1'b1,flit(1'b1,32'hB4),1'b1,8'd3);
    // len=2 with the FIFO going full in front of each payload flit
    add("032_accept",   1'b0,1'b1,32'h43,    8'd2, 1'b1,32'hFF,  1'b0, 1'b1,1'b0,1'b0,flit(1'b0,32'h0), 1'b0,8'd4);
    add("032_hdr",      1'b0,1'b0,32'h0,     8'd0, 1'b1,32'hC1,  1'b0, 1'b0,1'b0,1'b1,flit(1'b0,32'h43),1'b1,8'd4);
    add("032_full1",    1'b0,1'b0,32'h0,     8'd0, 1'b1,32'hC1,  1'b1, 1'b0,1'b0,1'b0,flit(1'b0,32'hC1),1'b1,8'd4);
    add("032_p1",       1'b0,1'b0,32'h0,     8'd0, 1'b1,32'hC1,  1'b0, 1'b0,1'b1,1'b1,flit(1'b0,32'hC1),1'b1,8'd4);
    add("032_full2",    1'b0,1'b0,32'h0,     8'd0, 1'b1,32'hC2,  1'b1, 1'b0,1'b0,1'b0,flit(1'b1,32'hC2),1'b1,8'd4);
    add("032_p2_tail",  1'b0,1'b0,32'h0,     8'd0, 1'b1,32'hC2,  1'b0, 1'b0,1'b1,1'b1,flit(1'b1,32'hC2),1'b1,8'd4);
    add("032_idle",     1'b0,1'b0,32'h0,     8'd0, 1'b0,32'h0,   1'b0, 1'b1,1'b0,1'b0,flit(1'b0,32'h0), 1'b0,8'd5);

    // Initial reset
    drive(1'b1, 1'b0, 32'h0, 8'd0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].srst, vecs[i].cv, vecs[i].hdr, vecs[i].len,
            vecs[i].pv, vecs[i].pd, vecs[i].full);
      check(vecs[i].name, vecs[i].e_cr, vecs[i].e_pr, vecs[i].e_wr,
            vecs[i].e_d, vecs[i].e_busy, vecs[i].e_cnt);
    end

    // Reset in the middle of a len=5 packet, after its 2nd payload flit
    drive(1'b0, 1'b1, 32'h50, 8'd5, 1'b0, 32'h0, 1'b0);
    check("043_accept", 1'b1, 1'b0, 1'b0, flit(1'b0, 32'h0), 1'b0, 8'd5);
    drive(1'b0, 1'b0, 32'h0, 8'd0, 1'b1, 32'hD1, 1'b0);
    check("043_hdr", 1'b0, 1'b0, 1'b1, flit(1'b0, 32'h50), 1'b1, 8'd5);
    drive(1'b0, 1'b0, 32'h0, 8'd0, 1'b1, 32'hD1, 1'b0);
    check("043_p1", 1'b0, 1'b1, 1'b1, flit(1'b0, 32'hD1), 1'b1, 8'd5);
    drive(1'b0, 1'b0, 32'h0, 8'd0, 1'b1, 32'hD2, 1'b0);
    check("043_p2", 1'b0, 1'b1, 1'b1, flit(1'b0, 32'hD2), 1'b1, 8'd5);
    drive(1'b1, 1'b0, 32'h0, 8'd0, 1'b0, 32'h0, 1'b0);
    check("043_rst_cycle", 1'b0, 1'b1, 1'b0, flit(1'b0, 32'h0), 1'b1, 8'd5);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0, 8'd0, 1'b1, 32'hD3, 1'b0);
      check("043_after_rst", 1'b1, 1'b0, 1'b0, flit(1'b0, 32'h0), 1'b0, 8'd0);
    end
    drive(1'b0, 1'b1, 32'h60, 8'd1, 1'b0, 32'h0, 1'b0);
    check("043_new_accept", 1'b1, 1'b0, 1'b0, flit(1'b0, 32'h0), 1'b0, 8'd0);
    drive(1'b0, 1'b0, 32'h0, 8'd0, 1'b0, 32'h0, 1'b0);
    check("043_new_hdr", 1'b0, 1'b0, 1'b1, flit(1'b0, 32'h60), 1'b1, 8'd0);
    drive(1'b0, 1'b0, 32'h0, 8'd0, 1'b1, 32'h61, 1'b0);
    check("043_new_tail", 1'b0, 1'b1, 1'b1, flit(1'b1, 32'h61), 1'b1, 8'd0);
    drive(1'b0, 1'b0, 32'h0, 8'd0, 1'b0, 32'h0, 1'b0);
    check("043_new_done", 1'b1, 1'b0, 1'b0, flit(1'b0, 32'h0), 1'b0, 8'd1);

    // Counter wrap: 2^CW-1 zero-length packets, then one more
    drive(1'b1, 1'b0, 32'h0, 8'd0, 1'b0, 32'h0, 1'b0);
    tick();
    bad_tails = 0;
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      drive(1'b0, 1'b1, 32'(i), 8'd0, 1'b0, 32'h0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 8'd0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      if (!(ingress_write === 1'b1 && ingress_data === flit(1'b1, 32'(i))))
        bad_tails++;
      tick();
    end
    n_tests++;
    if (bad_tails != 0) begin
      n_fail++;
      $display("FAIL 044_tails: got %0d bad single-flit packets, expected 0", bad_tails);
    end
    drive(1'b0, 1'b0, 32'h0, 8'd0, 1'b0, 32'h0, 1'b0);
    check("044_max", 1'b1, 1'b0, 1'b0, flit(1'b0, 32'h0), 1'b0, 8'hFF);
    drive(1'b0, 1'b1, 32'h77, 8'd0, 1'b0, 32'h0, 1'b0);
    check("044_accept", 1'b1, 1'b0, 1'b0, flit(1'b0, 32'h0), 1'b0, 8'hFF);
    drive(1'b0, 1'b0, 32'h0, 8'd0, 1'b0, 32'h0, 1'b0);
    check("044_hdr", 1'b0, 1'b0, 1'b1, flit(1'b1, 32'h77), 1'b1, 8'hFF);
    drive(1'b0, 1'b0, 32'h0, 8'd0, 1'b0, 32'h0, 1'b0);
    check("044_wrap", 1'b1, 1'b0, 1'b0, flit(1'b0, 32'h0), 1'b0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hynoc_packet_tx.md
HYNOC_PACKET_TX -- requirements
Module: hynoc_packet_tx

Interface
REQ-001 SHALL have parameter PAYLOAD_WIDTH, default 32: payload bits per flit.
REQ-002 SHALL have parameter FLIT_WIDTH, default PAYLOAD_WIDTH+1: flit width; bit FLIT_WIDTH-1 is the tail flag.
REQ-003 SHALL have parameter LEN_WIDTH, default 8: width of the payload-length field; maximum 2^LEN_WIDTH-1 payload flits.
REQ-004 SHALL have parameter CNT_WIDTH, default 16: width of the sent-packet counter.
REQ-005 router_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 router_srst  in  1  reset, synchronous and active-high.
REQ-007 cmd_valid  in  1  packet command present.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
REQ-009 cmd_header  in  PAYLOAD_WIDTH  routing header word.
REQ-010 cmd_length  in  LEN_WIDTH  number of payload flits following the header; 0 is legal.
REQ-011 pld_valid  in  1  payload word present.
REQ-012 pld_ready  out  1  payload word consumed when pld_valid&&pld_ready.
REQ-013 pld_data  in  PAYLOAD_WIDTH  payload word.
REQ-014 ingress_write  out  1  flit write strobe toward the router ingress FIFO.
REQ-015 ingress_data  out  FLIT_WIDTH  flit: {tail, payload}.
REQ-016 ingress_full  in  1  router ingress FIFO full.
REQ-017 busy  out  1  packet in progress (state not IDLE).
REQ-018 pkt_count  out  CNT_WIDTH  count of completed packets.

Function
REQ-019 SHALL implement FSM with states IDLE, HEADER, PAYLOAD.
REQ-020 IDLE: cmd_ready=1; on cmd_valid SHALL latch cmd_header into hdr_reg and cmd_length into remain_reg, then go to HEADER.
REQ-021 cmd_ready SHALL be 0 in HEADER and PAYLOAD; commands are never queued.
REQ-022 HEADER: ingress_write = !ingress_full; ingress_data = {remain_reg==0, hdr_reg}.
REQ-023 HEADER on write: go to PAYLOAD if remain_reg!=0; else go to IDLE and increment pkt_count.
REQ-024 PAYLOAD: pld_ready = !ingress_full; ingress_write = pld_valid && !ingress_full; ingress_data = {remain_reg==1, pld_data}.
REQ-025 PAYLOAD on write: remain_reg decrements by 1; when remain_reg was 1, go to IDLE and increment pkt_count.
REQ-026 ingress_write, ingress_data, and pld_ready SHALL be combinational from state, registers, pld_valid/pld_data, and ingress_full; no flit is written in any cycle where ingress_full=1.
REQ-027 Outside HEADER/PAYLOAD: ingress_write=0, pld_ready=0, ingress_data=0.
REQ-028 Latency: command accepted in cycle t gives header write at t+1 earliest; the first payload write occurs at t+2 earliest; back-to-back flits at 1 per cycle when full=0 and pld_valid=1.
REQ-029 Minimum packet spacing: an IDLE cycle separates packets, so a 0-length packet costs 2 cycles.
REQ-030 pkt_count SHALL wrap from 2^CNT_WIDTH-1 to 0.
REQ-031 pld_valid stall in PAYLOAD SHALL hold state and remain_reg, with no write.
REQ-032 ingress_full rising while a flit is pending SHALL stall with no loss and no duplicate; the flit is emitted the first cycle full=0.
REQ-033 pld_valid asserted in IDLE/HEADER SHALL NOT be consumed.
REQ-034 Exactly one flit per packet SHALL carry tail=1: the last flit.

Reset
REQ-035 On router_srst=1 at a clock edge: state=IDLE, hdr_reg=0, remain_reg=0, pkt_count=0.
REQ-036 Reset-derived outputs: ingress_write=0, pld_ready=0, busy=0, cmd_ready=1 from the next cycle.
REQ-037 Reset mid-packet SHALL abandon the packet with no tail emitted; recovery of the partial packet downstream is out of scope.
REQ-038 cmd_valid during reset SHALL NOT be accepted.

Verification
REQ-039 Command hdr=0x0000_0A05, len=3 with payload 0x11,0x22,0x33 and full=0: writes {0,0x0A05},{0,0x11},{0,0x22},{1,0x33} on consecutive cycles t+1..t+4; pkt_count=1.
REQ-040 len=0, hdr=0xABCD: single write {1,0xABCD} at t+1; busy low at t+2; cmd_ready high at t+2.
REQ-041 len=2, full=1 for 5 cycles starting at the header cycle: no write for 5 cycles, then 3 writes in order; no duplicates.
REQ-042 len=4 with pld_valid toggled 1,0,0,1,1,1: exactly 4 payload writes; tail on the 4th only.
REQ-043 router_srst pulsed after the 2nd payload flit of a len=5 packet: next cycle busy=0, pkt_count=0, no further writes; new len=1 packet transmits normally.
REQ-044 pkt_count preloaded via 65535 0-length packets, then 1 more: pkt_count reads 0.
